// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and common data bus outputs of the CDB arbiter.
// The arbiter is the slave; the functional units and the bus snoopers form the master side.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [NUM_FU-1:0]        fu_valid_i;
  logic [NUM_FU*TAG_W-1:0]  fu_tag_i;
  logic [NUM_FU*DATA_W-1:0] fu_data_i;
  logic [NUM_FU-1:0]        fu_ready_o;
  logic                     cdb_en_o;
  logic [TAG_W-1:0]         cdb_reg_addr_o;
  logic [DATA_W-1:0]        cdb_data_o;
  logic [CNT_W-1:0]         cdb_count_o;

  modport slave (
    input  fu_valid_i, fu_tag_i, fu_data_i,
    output fu_ready_o, cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_count_o
  );

  modport master (
    output fu_valid_i, fu_tag_i, fu_data_i,
    input  fu_ready_o, cdb_en_o, cdb_reg_addr_o, cdb_data_o, cdb_count_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter collecting functional-unit results and driving the registered CDB.
// One result is granted per cycle; the winner is broadcast the following cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  cdb_arbiter_if.slave        bus_io
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              en_q, en_d;
  logic [TAG_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_FU-1:0] gnt_c;
  logic [PTR_W-1:0]  gnt_idx_c;
  logic              gnt_vld_c;
  logic [TAG_W-1:0]  gnt_tag_c;
  logic [DATA_W-1:0] gnt_data_c;

  // Search from ptr upward modulo NUM_FU; reset and flush suppress any grant.
  always_comb begin
    logic [PTR_W-1:0] idx;
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    idx       = '0;
    if (reset_i && !flush_i) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        idx = PTR_W'((32'(ptr_q) + k) % NUM_FU);
        if (!gnt_vld_c && bus_io.fu_valid_i[idx]) begin
          gnt_vld_c      = 1'b1;
          gnt_idx_c      = idx;
          gnt_c[idx]     = 1'b1;
        end
      end
    end
  end

  // One-hot grant selects the winning payload.
  always_comb begin
    gnt_tag_c  = '0;
    gnt_data_c = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (gnt_c[i]) begin
        gnt_tag_c  = gnt_tag_c  | bus_io.fu_tag_i[i*TAG_W +: TAG_W];
        gnt_data_c = gnt_data_c | bus_io.fu_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    if (gnt_vld_c) begin
      ptr_d   = (32'(gnt_idx_c) == NUM_FU - 1) ? '0 : gnt_idx_c + PTR_W'(1);
      en_d    = 1'b1;
      addr_d  = gnt_tag_c;
      data_d  = gnt_data_c;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ptr_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus_io.fu_ready_o     = gnt_c;
  assign bus_io.cdb_en_o       = en_q;
  assign bus_io.cdb_reg_addr_o = addr_q;
  assign bus_io.cdb_data_o     = data_q;
  assign bus_io.cdb_count_o    = count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, saturation, rotation, flush, counter wrap.
module tb_cdb_arbiter;

  localparam int unsigned NUM_FU = 4;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic rst_n;
  logic flush;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic [TAG_W-1:0]  tag_tab  [NUM_FU];
  logic [DATA_W-1:0] data_tab [NUM_FU];

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .flush_i (flush),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of requests; exp_port < 0 means no grant expected.
  task automatic do_cycle(input logic [3:0] vld, input logic fl, input int exp_port);
    logic [3:0] exp_rdy;
    bus.fu_valid_i = vld;
    flush          = fl;
    exp_rdy        = (exp_port >= 0) ? 4'(1 << exp_port) : 4'b0000;
    #1;
    check_eq("fu_ready", 64'(bus.fu_ready_o), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (exp_port >= 0) begin
      exp_cnt = (exp_cnt + 1) % 16;
      check_eq("cdb_en", 64'(bus.cdb_en_o), 64'(1'b1));
      check_eq("cdb_addr", 64'(bus.cdb_reg_addr_o), 64'(tag_tab[exp_port]));
      check_eq("cdb_data", 64'(bus.cdb_data_o), 64'(data_tab[exp_port]));
    end else begin
      check_eq("cdb_en_idle", 64'(bus.cdb_en_o), 64'(1'b0));
    end
    check_eq("cdb_count", 64'(bus.cdb_count_o), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tag_tab[0]  = 5'd10; data_tab[0] = 32'hA000_0000;
    tag_tab[1]  = 5'd11; data_tab[1] = 32'hA000_0001;
    tag_tab[2]  = 5'd7;  data_tab[2] = 32'hDEAD_BEEF;
    tag_tab[3]  = 5'd0;  data_tab[3] = 32'hA000_0003;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      bus.fu_tag_i[i*TAG_W +: TAG_W]    = tag_tab[i];
      bus.fu_data_i[i*DATA_W +: DATA_W] = data_tab[i];
    end
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.fu_valid_i = 4'b1111;

    // Reset holds everything at zero, grant included.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(bus.fu_ready_o), 64'(0));
    check_eq("rst_en", 64'(bus.cdb_en_o), 64'(0));
    check_eq("rst_count", 64'(bus.cdb_count_o), 64'(0));
    bus.fu_valid_i = 4'b0000;
    rst_n          = 1'b1;

    // Single request from FU2.
    do_cycle(4'b0100, 1'b0, 2);
    do_cycle(4'b0000, 1'b0, -1);

    // Mid-stream reset: ptr=3 so FU1 wins, then reset with the broadcast visible.
    do_cycle(4'b0010, 1'b0, 1);
    bus.fu_valid_i = 4'b1111;
    rst_n          = 1'b0;
    #1;
    check_eq("midrst_ready", 64'(bus.fu_ready_o), 64'(0));
    check_eq("midrst_en", 64'(bus.cdb_en_o), 64'(0));
    check_eq("midrst_addr", 64'(bus.cdb_reg_addr_o), 64'(0));
    check_eq("midrst_data", 64'(bus.cdb_data_o), 64'(0));
    check_eq("midrst_count", 64'(bus.cdb_count_o), 64'(0));
    @(posedge clk);
    #1;
    bus.fu_valid_i = 4'b0000;
    rst_n          = 1'b1;
    exp_cnt        = 0;
    do_cycle(4'b0000, 1'b0, -1);

    // Saturation from ptr=0, then one more to leave the last grant on port 1.
    do_cycle(4'b1111, 1'b0, 0);
    do_cycle(4'b1111, 1'b0, 1);
    do_cycle(4'b1111, 1'b0, 2);
    do_cycle(4'b1111, 1'b0, 3);
    do_cycle(4'b1111, 1'b0, 0);
    do_cycle(4'b1111, 1'b0, 1);

    // Rotation past the last winner.
    do_cycle(4'b1010, 1'b0, 3);
    do_cycle(4'b1010, 1'b0, 1);

    // Flush: registered broadcast still visible, no new grant.
    bus.fu_valid_i = 4'b0001;
    flush          = 1'b1;
    #1;
    check_eq("flush_prev_en", 64'(bus.cdb_en_o), 64'(1));
    check_eq("flush_prev_addr", 64'(bus.cdb_reg_addr_o), 64'(tag_tab[1]));
    check_eq("flush_ready", 64'(bus.fu_ready_o), 64'(0));
    @(posedge clk);
    #1;
    check_eq("flush_en", 64'(bus.cdb_en_o), 64'(0));
    check_eq("flush_count", 64'(bus.cdb_count_o), 64'(exp_cnt));
    do_cycle(4'b0001, 1'b0, 0);

    // Eight more grants bring the total to 17; the 4-bit counter wraps to 1.
    do_cycle(4'b1111, 1'b0, 1);
    do_cycle(4'b1111, 1'b0, 2);
    do_cycle(4'b1111, 1'b0, 3);
    do_cycle(4'b1111, 1'b0, 0);
    do_cycle(4'b1111, 1'b0, 1);
    do_cycle(4'b1111, 1'b0, 2);
    do_cycle(4'b1111, 1'b0, 3);
    do_cycle(4'b1111, 1'b0, 0);
    check_eq("wrap_count", 64'(bus.cdb_count_o), 64'(1));
    do_cycle(4'b0000, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
